id_ex_decode: RTL
=================

# id_ex_decode

Decode stage and ID/EX pipeline register of the pipelined MIPS core. Turns the 32-bit instruction held in ID into the 3-bit ALU control word, operand-select, immediate and memory/writeback controls consumed by the EX-stage ALU. It also detects load-use hazards against the instruction currently in EX. Registered outputs, with stall hold and flush/bubble insertion.

## Interface
Parameters:
- none; widths fixed by the ISA (32-bit data, 5-bit register index).

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- id_instr  in  32  instruction word in ID
- id_valid  in  1  id_instr holds a real instruction
- stall  in  1  downstream hold; EX register keeps its contents
- flush  in  1  squash; EX register loads a bubble
- load_use_stall  out  1  combinational; ID must hold and re-present the same instruction next cycle
- ex_valid  out  1  EX slot holds a real instruction
- ex_alu_ctr  out  3  ALU control word
- ex_alu_src  out  1  1 = B operand is ex_imm, 0 = rt register
- ex_imm  out  32  extended immediate
- ex_rs, ex_rt, ex_dst  out  5 each  source indices; destination index
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  out  1 each  stage controls
- ex_illegal  out  1  unrecognised opcode/funct

## Operation
- ALU control encoding: bit2 = subtract, bit0 = signed (overflow-trapping for add/sub, signed compare for slt), {bit2&bit1} selects compare, {!bit2&bit1&!bit0} selects OR.
  - ADDU = 000, ADD = 001, OR = 010, SUBU = 100, SUB = 101, SLTU = 110, SLT = 111. 011 is never emitted.
- R-type (op 0x00), dst = rd, alu_src = 0:
  - funct 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU, 0x25 OR, 0x2A SLT, 0x2B SLTU.
- I-type, dst = rt, alu_src = 1:
  - addi 0x08 → ADD; addiu 0x09 → ADDU; slti 0x0A → SLT; sltiu 0x0B → SLTU (all sign-extended imm).
  - ori 0x0D → OR, zero-extended imm.
  - lui 0x0F → OR, imm = {imm16, 16'h0}.
  - lw 0x23 → ADDU, mem_read = 1, sign-extended imm.
  - sw 0x2B → ADDU, mem_write = 1, reg_write = 0, sign-extended imm.
  - beq 0x04 → SUBU, alu_src = 0, branch = 1, reg_write = 0.
- Instruction word 0x00000000 is NOP: valid, all controls 0, not illegal.
- Any other opcode/funct: ex_illegal = 1, reg_write = mem_read = mem_write = branch = 0, alu_ctr = 000.
- reg_write is forced 0 when dst = 0.
- Load-use hazard: id_valid & ex_valid & ex_mem_read & ex_dst != 0, and ex_dst equals either:
  - rs (all decoded instructions except lui and NOP), or
  - rt (R-type, sw, beq).
- Register update priority (highest first):
  - !rst_n → bubble.
  - flush → bubble.
  - stall → hold all ex_* outputs.
  - load_use_stall → bubble.
  - else load decoded fields with ex_valid = id_valid.
- Bubble: ex_valid = 0 and every ex_* output = 0.
- load_use_stall is also forced 0 while flush is asserted.

## Timing
- Decode-to-EX latency: 1 cycle; fields appear on the clock edge after acceptance.
- The ALU registers its result one further cycle later.
- Reset: all outputs 0 on the first edge with rst_n low; load_use_stall = 0 because ex_valid = 0. Reset mid-hazard or mid-stall simply clears EX.
- A hazard costs exactly one bubble. On the next cycle ex_mem_read = 0, so the stall releases.
- Stall and hazard together: EX holds and load_use_stall stays high until stall drops.
- Flush and stall together: flush wins.

## Structure
- Shared package mips_pkg:
  - opcode and funct constants;
  - ALU control constants ALU_ADDU … ALU_SLT;
  - a decoded-control struct (alu_ctr, alu_src, imm, dst, reg_write, mem_read, mem_write, branch, illegal).
- One combinational sub-module, instr_decode (instruction → struct). id_ex_decode wraps it with the hazard compare and the pipeline register.

## Test plan
- 0x00221820 (add $3,$1,$2) → next edge: ex_alu_ctr = 001, ex_rs = 1, ex_rt = 2, ex_dst = 3, ex_reg_write = 1, ex_alu_src = 0.
- 0x3406FFFF (ori) → ex_alu_ctr = 010, ex_imm = 0x0000FFFF. 0x2007FFFF (addi) → ex_alu_ctr = 001, ex_imm = 0xFFFFFFFF, ex_dst = 7.
- 0x8C240008 (lw $4,8($1)) then 0x00822822 (sub $5,$4,$2) → load_use_stall = 1 for one cycle, one bubble (ex_valid = 0), then sub enters with ex_alu_ctr = 101.
- Same load-use sequence with stall held 3 cycles → EX holds lw, load_use_stall = 1 throughout; one bubble after stall drops.
- 0xFC000000 → ex_illegal = 1, ex_reg_write = 0. Flush asserted with stall → ex_valid = 0.
- rst_n low mid-stream → all ex_* = 0 next edge; 0x00000000 afterwards → ex_valid = 1, no controls set.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS opcode/funct constants, ALU control words and the decoded-control records.
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    // bit2 = subtract, bit0 = signed, bit2&bit1 = compare, !bit2&bit1&!bit0 = OR
    typedef enum logic [2:0] {
        ALU_ADDU = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_OR   = 3'b010,
        ALU_SUBU = 3'b100,
        ALU_SUB  = 3'b101,
        ALU_SLTU = 3'b110,
        ALU_SLT  = 3'b111
    } alu_ctr_e;

    typedef struct packed {
        alu_ctr_e    alu_ctr;
        logic        alu_src;
        logic [31:0] imm;
        logic [4:0]  dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        illegal;
    } dec_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        dec_t       ctl;
    } ex_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction
endpackage

// File: rtl/id_ex_decode_instr_decode.sv
// instr_decode: combinational instruction word to decoded-control struct, plus which source registers are read.
module instr_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o,
    output logic        use_rs_o,
    output logic        use_rt_o
);
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic        nop;

    assign op    = instr_i[31:26];
    assign funct = instr_i[5:0];
    assign rt    = instr_i[20:16];
    assign rd    = instr_i[15:11];
    assign imm16 = instr_i[15:0];
    assign nop   = instr_i == '0;

    always_comb begin
        dec_o           = '0;
        dec_o.dst       = rt;
        dec_o.alu_src   = 1'b1;
        dec_o.imm       = sext16(imm16);
        dec_o.reg_write = 1'b1;
        use_rs_o        = 1'b1;
        use_rt_o        = 1'b0;
        case (op)
            OP_RTYPE: begin
                dec_o.dst     = rd;
                dec_o.alu_src = 1'b0;
                dec_o.imm     = '0;
                use_rt_o      = 1'b1;
                case (funct)
                    F_ADD:   dec_o.alu_ctr = ALU_ADD;
                    F_ADDU:  dec_o.alu_ctr = ALU_ADDU;
                    F_SUB:   dec_o.alu_ctr = ALU_SUB;
                    F_SUBU:  dec_o.alu_ctr = ALU_SUBU;
                    F_OR:    dec_o.alu_ctr = ALU_OR;
                    F_SLT:   dec_o.alu_ctr = ALU_SLT;
                    F_SLTU:  dec_o.alu_ctr = ALU_SLTU;
                    default: dec_o.illegal = 1'b1;
                endcase
            end
            OP_ADDI:  dec_o.alu_ctr = ALU_ADD;
            OP_ADDIU: dec_o.alu_ctr = ALU_ADDU;
            OP_SLTI:  dec_o.alu_ctr = ALU_SLT;
            OP_SLTIU: dec_o.alu_ctr = ALU_SLTU;
            OP_ORI: begin
                dec_o.alu_ctr = ALU_OR;
                dec_o.imm     = {16'h0, imm16};
            end
            OP_LUI: begin
                dec_o.alu_ctr = ALU_OR;
                dec_o.imm     = {imm16, 16'h0};
                use_rs_o      = 1'b0;
            end
            OP_LW: dec_o.mem_read = 1'b1;
            OP_SW: begin
                dec_o.mem_write = 1'b1;
                dec_o.reg_write = 1'b0;
                use_rt_o        = 1'b1;
            end
            OP_BEQ: begin
                dec_o.alu_ctr   = ALU_SUBU;
                dec_o.alu_src   = 1'b0;
                dec_o.branch    = 1'b1;
                dec_o.reg_write = 1'b0;
                use_rt_o        = 1'b1;
            end
            default: dec_o.illegal = 1'b1;
        endcase
        // the all-zero word decodes as an illegal R-type funct, so NOP is carved out here
        if (nop || dec_o.illegal) begin
            dec_o         = '0;
            dec_o.illegal = !nop;
            use_rs_o      = 1'b0;
            use_rt_o      = 1'b0;
        end
        dec_o.reg_write = dec_o.reg_write && dec_o.dst != '0;
    end
endmodule

// File: rtl/id_ex_decode.sv
// id_ex_decode: MIPS decode stage with load-use hazard detection and the ID/EX pipeline register.
module id_ex_decode
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] id_instr,
    input  logic        id_valid,
    input  logic        stall,
    input  logic        flush,
    output logic        load_use_stall,
    output logic        ex_valid,
    output logic [2:0]  ex_alu_ctr,
    output logic        ex_alu_src,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_dst,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_branch,
    output logic        ex_illegal
);
    dec_t       dec;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    ex_t        ex_q;
    ex_t        ex_d;

    instr_decode u_decode (
        .instr_i  (id_instr),
        .dec_o    (dec),
        .use_rs_o (use_rs),
        .use_rt_o (use_rt)
    );

    assign rs = id_instr[25:21];
    assign rt = id_instr[20:16];

    assign load_use_stall = !flush && id_valid && ex_q.valid && ex_q.ctl.mem_read && ex_q.ctl.dst != '0
                            && ((use_rs && rs == ex_q.ctl.dst) || (use_rt && rt == ex_q.ctl.dst));

    always_comb begin
        ex_d = ex_q;
        if (flush || (!stall && load_use_stall)) begin
            ex_d = '0;
        end else if (!stall) begin
            ex_d.valid = id_valid;
            ex_d.rs    = rs;
            ex_d.rt    = rt;
            ex_d.ctl   = dec;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    assign ex_valid     = ex_q.valid;
    assign ex_alu_ctr   = ex_q.ctl.alu_ctr;
    assign ex_alu_src   = ex_q.ctl.alu_src;
    assign ex_imm       = ex_q.ctl.imm;
    assign ex_rs        = ex_q.rs;
    assign ex_rt        = ex_q.rt;
    assign ex_dst       = ex_q.ctl.dst;
    assign ex_reg_write = ex_q.ctl.reg_write;
    assign ex_mem_read  = ex_q.ctl.mem_read;
    assign ex_mem_write = ex_q.ctl.mem_write;
    assign ex_branch    = ex_q.ctl.branch;
    assign ex_illegal   = ex_q.ctl.illegal;
endmodule
